// File: rtl/rv32i_lsu_pkg.sv
// rv32i_lsu_pkg: shared state type, funct3 codes, widths and alignment
// helpers for the RV32I load/store bus bridge.
package rv32i_lsu_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_t;

  // Access size from funct3; anything not byte or half is a word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    lsu_size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  // True when the low address bits break the natural alignment of the access.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3_size(f3))
      SZ_H:    mis = lo[0];
      SZ_W:    mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Low address bits forced to the natural alignment of the access.
  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] al;
    case (f3_size(f3))
      SZ_H:    al = {lo[1], 1'b0};
      SZ_W:    al = 2'b00;
      default: al = lo;
    endcase
    return al;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering. Store side builds byte
// enables and replicated write data; load side selects and extends the
// addressed byte/half of the returned word.
module lsu_align
  import rv32i_lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_word,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_fmt
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: replicate the datum across lanes and enable only the addressed bytes.
  always_comb begin
    be    = 4'b1111;
    wdata = wr_data;
    case (f3_size(funct3))
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{wr_data[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{wr_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wr_data;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then sign- or zero-extend (funct3[2] = unsigned).
  always_comb begin
    case (addr_lo)
      2'b00:   byte_s = rd_word[7:0];
      2'b01:   byte_s = rd_word[15:8];
      2'b10:   byte_s = rd_word[23:16];
      default: byte_s = rd_word[31:24];
    endcase
    if (addr_lo[1]) begin
      half_s = rd_word[31:16];
    end else begin
      half_s = rd_word[15:0];
    end
    case (f3_size(funct3))
      SZ_B: begin
        if (funct3[2]) begin
          rd_fmt = {24'h000000, byte_s};
        end else begin
          rd_fmt = {{24{byte_s[7]}}, byte_s};
        end
      end
      SZ_H: begin
        if (funct3[2]) begin
          rd_fmt = {16'h0000, half_s};
        end else begin
          rd_fmt = {{16{half_s[15]}}, half_s};
        end
      end
      default: rd_fmt = rd_word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: single-outstanding load/store bridge between the RV32I
// datapath and a valid/ready data bus. Stalls the core for the whole access
// and returns formatted load data with a one-cycle oDone pulse.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// complete immediately with oBusErr instead of being silently aligned.
module lsu_bus_bridge
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int          ADDR_W         = 32
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iReq,
  input  logic              iWe,
  input  logic [2:0]        iFunct3,
  input  logic [31:0]       iAddr,
  input  logic [31:0]       iWrData,
  output logic              oStall,
  output logic              oDone,
  output logic [31:0]       oRdData,
  output logic              oBusErr,
  output logic              oBus_Valid,
  output logic              oBus_We,
  output logic [ADDR_W-1:0] oBus_Addr,
  output logic [3:0]        oBus_Be,
  output logic [31:0]       oBus_WData,
  input  logic              iBus_Ready,
  input  logic              iBus_RValid,
  input  logic [31:0]       iBus_RData
);

  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

  lsu_state_t  state_r, state_next_s;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [31:0] cnt_r;
  logic [31:0] rd_data_r;
  logic        err_r;

  logic [2:0]  sel_f3_s;
  logic [1:0]  sel_lo_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] rd_fmt_s;
  logic        misalign_s;
  logic        timeout_s;
  logic        capture_s;
  logic        err_next_s;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = is_misaligned(iFunct3, iAddr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign timeout_s = TMO_EN && (cnt_r == TMO_LAST);

  // Lane steering sees the live request while idle and the latched access afterwards.
  always_comb begin
    if (state_r == IDLE) begin
      sel_f3_s = iFunct3;
      sel_lo_s = align_lo(iFunct3, iAddr[1:0]);
    end else begin
      sel_f3_s = f3_r;
      sel_lo_s = addr_r[1:0];
    end
  end

  lsu_align u_align (
    .funct3  (sel_f3_s),
    .addr_lo (sel_lo_s),
    .wr_data (iWrData),
    .rd_word (iBus_RData),
    .be      (be_s),
    .wdata   (wdata_s),
    .rd_fmt  (rd_fmt_s)
  );

  // Next-state and control decode; Ready/RValid win over a same-cycle timeout.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    err_next_s   = 1'b0;
    oStall       = 1'b0;
    oBus_Valid   = 1'b0;
    oDone        = 1'b0;
    case (state_r)
      IDLE: begin
        oStall = iReq & iRst_n;
        if (iReq) begin
          if (misalign_s) begin
            state_next_s = DONE;
            err_next_s   = 1'b1;
          end else begin
            state_next_s = REQ;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        oStall     = 1'b1;
        oBus_Valid = 1'b1;
        if (iBus_Ready) begin
          if (we_r) begin
            state_next_s = DONE;
          end else if (iBus_RValid) begin
            state_next_s = DONE;
            capture_s    = 1'b1;
          end else begin
            state_next_s = RESP;
          end
        end else if (timeout_s) begin
          state_next_s = DONE;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = REQ;
        end
      end
      RESP: begin
        oStall = 1'b1;
        if (iBus_RValid) begin
          state_next_s = DONE;
          capture_s    = 1'b1;
        end else if (timeout_s) begin
          state_next_s = DONE;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = RESP;
        end
      end
      DONE: begin
        oDone        = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register, timeout counter, request latches and completion results.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 32'd0;
      we_r      <= 1'b0;
      f3_r      <= 3'b000;
      addr_r    <= 32'd0;
      be_r      <= 4'b0000;
      wdata_r   <= 32'd0;
      rd_data_r <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if ((state_next_s != state_r) || !((state_r == REQ) || (state_r == RESP))) begin
        cnt_r <= 32'd0;
      end else begin
        cnt_r <= cnt_r + 32'd1;
      end
      if ((state_r == IDLE) && iReq) begin
        we_r    <= iWe;
        f3_r    <= iFunct3;
        addr_r  <= {iAddr[31:2], sel_lo_s};
        be_r    <= be_s;
        wdata_r <= wdata_s;
      end
      if (state_next_s == DONE) begin
        rd_data_r <= capture_s ? rd_fmt_s : 32'd0;
      end
      err_r <= err_next_s;
    end
  end

  assign oBus_We    = we_r;
  assign oBus_Addr  = ADDR_W'({addr_r[31:2], 2'b00});
  assign oBus_Be    = be_r;
  assign oBus_WData = wdata_r;
  assign oRdData    = rd_data_r;
  assign oBusErr    = err_r;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: randomized accesses against a transaction-level model
// of the load/store bridge, plus directed vectors with literal expectations.
module tb_lsu_bus_bridge;

  localparam int T = 4;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iReq = 1'b0;
  logic        iWe = 1'b0;
  logic [2:0]  iFunct3 = 3'b000;
  logic [31:0] iAddr = 32'd0;
  logic [31:0] iWrData = 32'd0;
  logic        iBus_Ready = 1'b0;
  logic        iBus_RValid = 1'b0;
  logic [31:0] iBus_RData = 32'd0;
  logic        oStall, oDone, oBusErr, oBus_Valid, oBus_We;
  logic [31:0] oRdData, oBus_Addr, oBus_WData;
  logic [3:0]  oBus_Be;

  int checks = 0;
  int errors = 0;

  // Model expectations for the access in flight
  logic        in_txn = 1'b0;
  logic        skip_cmp = 1'b1;
  int          cyc = 0;
  int          exp_done_cyc = 0;
  int          exp_req_last = 0;
  logic [31:0] exp_addr, exp_wdata, exp_rd;
  logic [3:0]  exp_be;
  logic        exp_we, exp_err;

  // Values seen on the DUT during the last access
  logic [31:0] cap_addr, cap_wdata, cap_rd;
  logic [3:0]  cap_be;
  logic        cap_err;
  int          cap_stall, cap_valid, cap_done_cyc;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iWe(iWe), .iFunct3(iFunct3),
    .iAddr(iAddr), .iWrData(iWrData), .oStall(oStall), .oDone(oDone),
    .oRdData(oRdData), .oBusErr(oBusErr), .oBus_Valid(oBus_Valid),
    .oBus_We(oBus_We), .oBus_Addr(oBus_Addr), .oBus_Be(oBus_Be),
    .oBus_WData(oBus_WData), .iBus_Ready(iBus_Ready),
    .iBus_RValid(iBus_RValid), .iBus_RData(iBus_RData)
  );

  always #5 iClk = ~iClk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  // Build the expected outcome of one access and drive it cycle by cycle.
  // rd = REQ cycles before Ready; vd = cycles from Ready to RValid (0 = same cycle).
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wr, input logic [31:0] rdata,
                            input int rd, input int vd);
    int sz, lane;
    logic [31:0] mask, val;
    logic accept, rv;
    sz   = size_of(f3);
    lane = int'(addr[1:0]) - (int'(addr[1:0]) % sz);
    mask = (sz == 1) ? 32'h0000_00FF : (sz == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    val  = (rdata >> (8 * lane)) & mask;
    if (sz < 4 && !f3[2] && val[8 * sz - 1]) val = val | ~mask;
    exp_we    = we;
    exp_addr  = addr - (addr % 32'd4);
    exp_be    = 4'(((1 << sz) - 1) << lane);
    exp_wdata = (sz == 1) ? wr[7:0] * 32'h0101_0101 :
                (sz == 2) ? wr[15:0] * 32'h0001_0001 : wr;
    accept    = (rd < T);
    exp_req_last = accept ? 1 + rd : T;
    exp_err = 1'b0;
    if (!accept) begin
      exp_done_cyc = T + 1;
      exp_err = 1'b1;
    end else if (we || vd == 0) begin
      exp_done_cyc = 2 + rd;
    end else if (vd - 1 >= T) begin
      exp_done_cyc = 2 + rd + T;
      exp_err = 1'b1;
    end else begin
      exp_done_cyc = 2 + rd + vd;
    end
    exp_rd = (exp_err || we) ? 32'd0 : val;
    for (int c = 0; c <= exp_done_cyc; c++) begin
      cyc = c;
      if (c == 0) begin
        iReq = 1'b1; iWe = we; iFunct3 = f3; iAddr = addr; iWrData = wr;
        cap_addr = 32'hFFFF_FFFF; cap_wdata = 32'd0; cap_be = 4'b0000;
        cap_rd = 32'h5A5A_5A5A; cap_err = 1'bx;
        cap_stall = 0; cap_valid = 0; cap_done_cyc = -1;
        in_txn = 1'b1;
      end else begin
        iReq = ($urandom_range(0, 3) != 0);
        iWe = 1'($urandom); iFunct3 = 3'($urandom);
        iAddr = $urandom; iWrData = $urandom;
      end
      iBus_Ready = accept && (c == 1 + rd);
      rv = !we && accept && ((vd == 0 && c == 1 + rd) || (vd > 0 && vd - 1 < T && c == 1 + rd + vd));
      iBus_RValid = rv;
      iBus_RData = rv ? rdata : $urandom;
      @(posedge iClk); #1;
    end
    in_txn = 1'b0;
  endtask

  task automatic idle(input int n);
    in_txn = 1'b0; iReq = 1'b0; iBus_Ready = 1'b0; iBus_RValid = 1'b0;
    repeat (n) begin @(posedge iClk); #1; end
  endtask

  // Per-cycle compare against the model, mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge iClk);
      if (!skip_cmp) begin
        if (in_txn) begin
          chk1("stall", oStall, cyc < exp_done_cyc);
          chk1("bus_valid", oBus_Valid, (cyc >= 1) && (cyc <= exp_req_last));
          chk1("done", oDone, cyc == exp_done_cyc);
          if (oStall) cap_stall++;
          if (oBus_Valid && cyc >= 1 && cyc <= exp_req_last) begin
            cap_valid++;
            cap_addr = oBus_Addr; cap_be = oBus_Be; cap_wdata = oBus_WData;
            chk32("bus_addr", oBus_Addr, exp_addr);
            chk1("bus_we", oBus_We, exp_we);
            chk32("bus_be", {28'd0, oBus_Be}, {28'd0, exp_be});
            if (exp_we) chk32("bus_wdata", oBus_WData, exp_wdata);
          end
          if (oDone && cyc == exp_done_cyc) begin
            cap_rd = oRdData; cap_err = oBusErr; cap_done_cyc = cyc;
            chk32("rd_data", oRdData, exp_rd);
            chk1("bus_err", oBusErr, exp_err);
          end else begin
            chk1("bus_err_quiet", oBusErr, 1'b0);
          end
        end else begin
          chk32("idle_ctl", {28'd0, oStall, oBus_Valid, oDone, oBusErr}, 32'd0);
        end
      end
    end
  end

  initial begin
    int we_i, rd_i, vd_i;
    logic [2:0] f3_i;
    iRst_n = 1'b0;
    #12;
    chk32("reset_ctl", {27'd0, oStall, oDone, oBusErr, oBus_Valid, oBus_We}, 32'd0);
    chk32("reset_addr", oBus_Addr, 32'd0);
    chk32("reset_be", {28'd0, oBus_Be}, 32'd0);
    chk32("reset_wdata", oBus_WData, 32'd0);
    chk32("reset_rd", oRdData, 32'd0);
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    @(posedge iClk); #1;
    skip_cmp = 1'b0;

    // SW with immediate Ready
    run_access(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 0, 0);
    chk32("sw_addr", cap_addr, 32'h0000_0104);
    chk32("sw_be", {28'd0, cap_be}, 32'h0000_000F);
    chk32("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk32("sw_done_cycle", cap_done_cyc, 32'd2);
    chk32("sw_stall_cycles", cap_stall, 32'd2);
    // SB at top lane
    run_access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0, 0);
    chk32("sb_be", {28'd0, cap_be}, 32'h0000_0008);
    chk32("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk32("sb_addr", cap_addr, 32'h0000_0100);
    // LB / LBU, RValid two cycles after Ready
    run_access(1'b0, 3'b000, 32'h0000_0202, 32'd0, 32'h1280_FF34, 0, 2);
    chk32("lb_data", cap_rd, 32'hFFFF_FF80);
    chk32("lb_done_cycle", cap_done_cyc, 32'd4);
    run_access(1'b0, 3'b100, 32'h0000_0202, 32'd0, 32'h1280_FF34, 0, 2);
    chk32("lbu_data", cap_rd, 32'h0000_0080);
    // LH / LHU
    run_access(1'b0, 3'b001, 32'h0000_0302, 32'd0, 32'h8001_0000, 1, 1);
    chk32("lh_data", cap_rd, 32'hFFFF_8001);
    run_access(1'b0, 3'b101, 32'h0000_0302, 32'd0, 32'h8001_0000, 0, 0);
    chk32("lhu_data", cap_rd, 32'h0000_8001);
    // Timeout with Ready never asserted
    run_access(1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h1234_5678, 9, 0);
    chk1("tmo_err", cap_err, 1'b1);
    chk32("tmo_rd", cap_rd, 32'd0);
    chk32("tmo_done_cycle", cap_done_cyc, 32'd5);
    chk32("tmo_valid_cycles", cap_valid, 32'd4);
    idle(1);
    // Timeout while waiting for read data
    run_access(1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'h1234_5678, 0, 7);
    chk1("resp_tmo_err", cap_err, 1'b1);
    chk32("resp_tmo_done_cycle", cap_done_cyc, 32'd6);
    // Misaligned LW is aligned down and completes normally
    run_access(1'b0, 3'b010, 32'h0000_0001, 32'd0, 32'hCAFE_F00D, 0, 0);
    chk32("mis_lw_addr", cap_addr, 32'h0000_0000);
    chk32("mis_lw_data", cap_rd, 32'hCAFE_F00D);
    chk1("mis_lw_err", cap_err, 1'b0);
    idle(2);

    // Asynchronous reset while waiting for read data
    skip_cmp = 1'b1;
    iReq = 1'b1; iWe = 1'b0; iFunct3 = 3'b010; iAddr = 32'h0000_0040;
    iBus_Ready = 1'b0; iBus_RValid = 1'b0;
    @(posedge iClk); #1;
    iBus_Ready = 1'b1;
    @(posedge iClk); #1;
    iBus_Ready = 1'b0;
    chk1("resp_stall_before_reset", oStall, 1'b1);
    chk1("resp_valid_before_reset", oBus_Valid, 1'b0);
    #2;
    iRst_n = 1'b0;
    #1;
    chk32("mid_reset_ctl", {29'd0, oBus_Valid, oStall, oDone}, 32'd0);
    iReq = 1'b0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    @(posedge iClk); #1;
    skip_cmp = 1'b0;

    // Randomized accesses, including back-to-back and timeout boundaries
    for (int n = 0; n < 400; n++) begin
      we_i = int'($urandom_range(0, 1));
      f3_i = (we_i != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      rd_i = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T, T + 2)) : int'($urandom_range(0, T - 1));
      vd_i = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T + 1, T + 3)) : int'($urandom_range(0, T));
      run_access(we_i != 0, f3_i, $urandom, $urandom, $urandom, rd_i, vd_i);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
